// File: rtl/rx_bit_timer.sv
// Bit timer: start pulse -> per-bit sample strobes and an end-of-frame pulse.
// Outputs are decoded from registered state only, one cycle after the controlling edge.
module rx_bit_timer #(
  parameter int BIT_PERIOD   = 8,
  parameter int SAMPLE_POINT = 3,
  parameter int NUM_BITS     = 8,
  localparam int CW = $clog2(BIT_PERIOD),
  localparam int BW = $clog2(NUM_BITS + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic          abort,
  output logic          shift_strobe,
  output logic          byte_done,
  output logic          busy,
  output logic [BW-1:0] bit_index
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CW-1:0] CLK_LAST = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] SAMPLE   = CW'(SAMPLE_POINT);
  localparam logic [BW-1:0] BIT_LAST = BW'(NUM_BITS - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = COUNT;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      COUNT: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = DONE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      DONE: begin
        // A start in the DONE cycle chains straight into the next frame.
        state_d   = start ? COUNT : IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase
    if (abort) begin
      state_d   = IDLE;
      clk_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign shift_strobe = (state_q == COUNT) && (clk_cnt_q == SAMPLE);
  assign byte_done    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign bit_index    = bit_cnt_q;

endmodule

// File: doc/rx_bit_timer.md
# rx_bit_timer

Bit-timing controller that turns a start-of-frame pulse into per-bit sample strobes and an end-of-byte pulse. It sits downstream of the receive edge detector and upstream of the receive shift register. Internally it is a clocks-per-bit counter chained to a bit counter, the same divide-and-count structure as our flex counters, plus a small FSM. Its `shift_strobe` drives the shift register's shift enable, and `byte_done` drives the RX control FSM.

## Interface
- `BIT_PERIOD`, default 8: clocks per bit; must be ≥ 2.
- `SAMPLE_POINT`, default 3: clock offset within a bit at which the strobe fires; 0 ≤ `SAMPLE_POINT` < `BIT_PERIOD`.
- `NUM_BITS`, default 8: bits per frame; must be ≥ 1.
- Derived widths:
  - `CW` = `$clog2(BIT_PERIOD)`
  - `BW` = `$clog2(NUM_BITS+1)`

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `n_rst`  in  1  reset. One clock; reset is asynchronous and active-high (`n_rst`=1 resets immediately, independent of `clk`).
- `start`  in  1  single-cycle pulse from the edge detector marking the start-of-frame edge.
- `abort`  in  1  synchronous cancel, e.g. on an EOP or line error.
- `shift_strobe`  out  1  one-cycle pulse at the sample point of each bit.
- `byte_done`  out  1  one-cycle pulse after all `NUM_BITS` bits have elapsed.
- `busy`  out  1  high whenever the FSM is not IDLE.
- `bit_index`  out  BW  index of the current bit (0..`NUM_BITS`-1); 0 in IDLE.

## Operation
- State: FSM {IDLE, COUNT, DONE}, `clk_cnt`[CW], `bit_cnt`[BW].
- Reset: state IDLE, both counters 0. All outputs are 0 while reset is asserted and after it.
- IDLE:
  - `start`=1 → COUNT, with `clk_cnt`=0 and `bit_cnt`=0.
  - Otherwise hold.
- COUNT:
  - Each cycle, `clk_cnt`++.
  - When `clk_cnt`==`BIT_PERIOD`-1 it wraps to 0 and `bit_cnt`++.
  - When `clk_cnt`==`BIT_PERIOD`-1 and `bit_cnt`==`NUM_BITS`-1 → DONE, counters cleared.
  - `start` is ignored in COUNT (no restart mid-frame).
- DONE:
  - Lasts exactly one cycle.
  - `start`=1 → COUNT with counters 0 (back-to-back frames).
  - Otherwise → IDLE.
- `abort`:
  - Highest priority of all synchronous inputs. Next state is IDLE and counters are cleared, from any state.
  - `byte_done` does not fire for an aborted frame.
  - `abort` together with `start` in IDLE → stay IDLE.
- Outputs are decoded combinationally from registered state only; no input reaches an output combinationally.
  - `shift_strobe` = (state==COUNT) && (`clk_cnt`==`SAMPLE_POINT`)
  - `byte_done` = (state==DONE)
  - `busy` = (state!=IDLE)
  - `bit_index` = `bit_cnt`
- Counter comparisons use full-width equality. Counters never exceed their terminal values (no overflow path).

## Timing
- `start` is sampled at edge E0. Then:
  - `busy` rises in the cycle after E0.
  - Bit n (0-based) strobes in the cycle following edge E0 + n·`BIT_PERIOD` + `SAMPLE_POINT`.
  - `bit_index` equals n during bit n's `BIT_PERIOD` cycles.
  - `byte_done` is high in the cycle following edge E0 + `NUM_BITS`·`BIT_PERIOD`.
  - `busy` falls after edge E0 + `NUM_BITS`·`BIT_PERIOD` + 1, unless the FSM restarts.
- Latency from `start` to first strobe: `SAMPLE_POINT`+1 cycles.
- Back-to-back: with `start` high in the DONE cycle, the next frame's first strobe follows the same timing relative to that edge. `busy` stays continuously high across the two frames.
- Asserting `n_rst` mid-frame clears all outputs immediately, before the next clock edge. After release the block waits in IDLE for a new `start`.

## Test plan
- Reset: hold `n_rst`=1 mid-COUNT → `shift_strobe`, `byte_done`, `busy`, `bit_index` all 0 immediately. After release, idle with `start`=0 for 20 cycles → outputs stay 0.
- Nominal frame (defaults): `start` at edge 0 →
  - 8 strobes, in the cycles after edges 3, 11, 19, …, 59.
  - `bit_index` steps 0..7.
  - `byte_done` high in the cycle after edge 64 only.
  - `busy` high in the cycles after edges 0..64.
- Back-to-back: `start` asserted in the DONE cycle → second frame's first strobe 4 cycles later. `busy` never drops. Exactly 16 strobes and 2 `byte_done` pulses in total.
- Ignored restart: pulse `start` at cycle 20 mid-frame → strobe timing unchanged from the nominal case.
- Abort: `abort` at cycle 30 → IDLE next cycle, `busy`=0, no `byte_done`, no further strobes. A fresh `start` afterwards yields the nominal timing.
- Parameter corner: `BIT_PERIOD`=2, `SAMPLE_POINT`=1, `NUM_BITS`=1 → one strobe in the cycle after edge 1, `byte_done` in the cycle after edge 2.
